// File: rtl/lsu_controller.sv
// Load/store sequencing controller: accepts one request at a time, lane-aligns stores,
// runs a valid/ready memory handshake and sign/zero-extends load data for write-back.
module lsu_controller #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic        store_done,
  output logic        err_misaligned,
  output logic        err_funct3,
  output logic        err_timeout,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // The request side is ready only in IDLE; the memory side holds its payload until ready.

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_RSP = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [2:0] F3_BYTE      = 3'b000;
  localparam logic [2:0] F3_HALFWORD  = 3'b001;
  localparam logic [2:0] F3_WORD      = 3'b010;
  localparam logic [2:0] F3_BYTE_U    = 3'b100;
  localparam logic [2:0] F3_HALFWORD_U = 3'b101;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             mem_we_q, mem_we_d;
  logic [3:0]       mem_byte_en_q, mem_byte_en_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             store_done_q, store_done_d;
  logic             err_misaligned_q, err_misaligned_d;
  logic             err_funct3_q, err_funct3_d;
  logic             err_timeout_q, err_timeout_d;

  logic             f3_bad;
  logic             misaligned;
  logic [3:0]       st_byte_en;
  logic [31:0]      st_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;

  // Request decode: legality, alignment and store lane placement.
  always_comb begin
    f3_bad     = 1'b0;
    misaligned = 1'b0;
    st_byte_en = 4'b1111;
    st_wdata   = req_wdata;
    if (req_is_store) begin
      f3_bad = !((req_funct3 == F3_BYTE) || (req_funct3 == F3_HALFWORD) ||
                 (req_funct3 == F3_WORD));
    end else begin
      f3_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    if (req_funct3[1:0] == 2'b01) begin
      misaligned = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misaligned = (req_addr[1:0] != 2'b00);
    end
    case (req_funct3)
      F3_BYTE: begin
        st_byte_en = 4'b0001 << req_addr[1:0];
        st_wdata   = {4{req_wdata[7:0]}};
      end
      F3_HALFWORD: begin
        st_byte_en = 4'b0011 << req_addr[1:0];
        st_wdata   = {2{req_wdata[15:0]}};
      end
      default: begin
        st_byte_en = 4'b1111;
        st_wdata   = req_wdata;
      end
    endcase
  end

  // Load lane extraction from the latched offset and funct3.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      F3_BYTE:       ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_BYTE_U:     ld_ext = {24'h0, ld_byte};
      F3_HALFWORD:   ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_HALFWORD_U: ld_ext = {16'h0, ld_half};
      default:       ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    funct3_d         = funct3_q;
    off_d            = off_q;
    mem_addr_d       = mem_addr_q;
    mem_we_d         = mem_we_q;
    mem_byte_en_d    = mem_byte_en_q;
    mem_wdata_d      = mem_wdata_q;
    wb_data_d        = wb_data_q;
    store_done_d     = 1'b0;
    err_misaligned_d = 1'b0;
    err_funct3_d     = 1'b0;
    err_timeout_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (f3_bad) begin
            err_funct3_d = 1'b1;
          end else if (misaligned) begin
            err_misaligned_d = 1'b1;
          end else begin
            state_d       = S_REQ;
            funct3_d      = req_funct3;
            off_d         = req_addr[1:0];
            mem_addr_d    = {req_addr[31:2], 2'b00};
            mem_we_d      = req_is_store;
            mem_byte_en_d = req_is_store ? st_byte_en : 4'b1111;
            mem_wdata_d   = req_is_store ? st_wdata : 32'h0;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (mem_we_q) begin
            store_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT_RSP;
          end
        end
      end
      S_WAIT_RSP: begin
        // A response arriving on the final count takes precedence over the timeout.
        if (mem_rvalid) begin
          wb_data_d = ld_ext;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      funct3_q         <= 3'b000;
      off_q            <= 2'b00;
      mem_addr_q       <= 32'h0;
      mem_we_q         <= 1'b0;
      mem_byte_en_q    <= 4'b0000;
      mem_wdata_q      <= 32'h0;
      wb_data_q        <= 32'h0;
      store_done_q     <= 1'b0;
      err_misaligned_q <= 1'b0;
      err_funct3_q     <= 1'b0;
      err_timeout_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      funct3_q         <= funct3_d;
      off_q            <= off_d;
      mem_addr_q       <= mem_addr_d;
      mem_we_q         <= mem_we_d;
      mem_byte_en_q    <= mem_byte_en_d;
      mem_wdata_q      <= mem_wdata_d;
      wb_data_q        <= wb_data_d;
      store_done_q     <= store_done_d;
      err_misaligned_q <= err_misaligned_d;
      err_funct3_q     <= err_funct3_d;
      err_timeout_q    <= err_timeout_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign mem_req_valid  = (state_q == S_REQ);
  assign wb_valid       = (state_q == S_RESP);
  assign busy           = (state_q != S_IDLE);
  assign mem_addr       = mem_addr_q;
  assign mem_we         = mem_we_q;
  assign mem_byte_en    = mem_byte_en_q;
  assign mem_wdata      = mem_wdata_q;
  assign wb_data        = wb_data_q;
  assign store_done     = store_done_q;
  assign err_misaligned = err_misaligned_q;
  assign err_funct3     = err_funct3_q;
  assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: stores, loads, errors, backpressure, timeout and reset.
module tb_lsu_controller;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic        store_done;
  logic        err_misaligned;
  logic        err_funct3;
  logic        err_timeout;
  logic        busy;

  int vec_cnt;
  int err_cnt;

  lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_byte_en(mem_byte_en),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_data(wb_data), .wb_valid(wb_valid), .store_done(store_done),
    .err_misaligned(err_misaligned), .err_funct3(err_funct3),
    .err_timeout(err_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    vec_cnt++; if ({mem_req_valid, mem_we, mem_byte_en, busy} !== 7'b0) begin err_cnt++; $display("FAIL rst_mem_ctl got=%b exp=0", {mem_req_valid, mem_we, mem_byte_en, busy}); end
    vec_cnt++; if ({mem_addr, mem_wdata, wb_data} !== 96'h0) begin err_cnt++; $display("FAIL rst_data got=%h exp=0", {mem_addr, mem_wdata, wb_data}); end
    vec_cnt++; if ({wb_valid, store_done, err_misaligned, err_funct3, err_timeout} !== 5'b0) begin err_cnt++; $display("FAIL rst_pulses got=%b exp=0", {wb_valid, store_done, err_misaligned, err_funct3, err_timeout}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sb();
    accept(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    vec_cnt++; if ({mem_req_valid, mem_we, req_ready} !== 3'b110) begin err_cnt++; $display("FAIL sb_ctl got=%b exp=110", {mem_req_valid, mem_we, req_ready}); end
    vec_cnt++; if (mem_addr !== 32'h0000_1000) begin err_cnt++; $display("FAIL sb_addr got=%h exp=00001000", mem_addr); end
    vec_cnt++; if (mem_byte_en !== 4'b1000) begin err_cnt++; $display("FAIL sb_byte_en got=%b exp=1000", mem_byte_en); end
    vec_cnt++; if (mem_wdata !== 32'hDDDD_DDDD) begin err_cnt++; $display("FAIL sb_wdata got=%h exp=dddddddd", mem_wdata); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    vec_cnt++; if ({store_done, req_ready, mem_req_valid} !== 3'b110) begin err_cnt++; $display("FAIL sb_done got=%b exp=110", {store_done, req_ready, mem_req_valid}); end
    tick();
    vec_cnt++; if (store_done !== 1'b0) begin err_cnt++; $display("FAIL sb_done_width got=%b exp=0", store_done); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] adr_tab [5] = '{32'h2002, 32'h2002, 32'h2002, 32'h2002, 32'h2000};
    logic [31:0] exp_tab [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF,
                                 32'h0000_80FF, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      accept(1'b0, f3_tab[i], adr_tab[i], 32'h5555_5555);
      vec_cnt++; if ({mem_req_valid, mem_we, mem_byte_en} !== 6'b10_1111) begin err_cnt++; $display("FAIL ld%0d_req got=%b exp=101111", i, {mem_req_valid, mem_we, mem_byte_en}); end
      vec_cnt++; if (mem_addr !== 32'h0000_2000) begin err_cnt++; $display("FAIL ld%0d_addr got=%h exp=00002000", i, mem_addr); end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      vec_cnt++; if ({busy, wb_valid, mem_req_valid} !== 3'b100) begin err_cnt++; $display("FAIL ld%0d_wait got=%b exp=100", i, {busy, wb_valid, mem_req_valid}); end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h80FF_7F01;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h1234_5678;
      vec_cnt++; if (wb_valid !== 1'b1) begin err_cnt++; $display("FAIL ld%0d_wb_valid got=%b exp=1", i, wb_valid); end
      vec_cnt++; if (wb_data !== exp_tab[i]) begin err_cnt++; $display("FAIL ld%0d_wb_data got=%h exp=%h", i, wb_data, exp_tab[i]); end
      tick();
      vec_cnt++; if ({wb_valid, req_ready} !== 2'b01) begin err_cnt++; $display("FAIL ld%0d_after got=%b exp=01", i, {wb_valid, req_ready}); end
      vec_cnt++; if (wb_data !== exp_tab[i]) begin err_cnt++; $display("FAIL ld%0d_hold got=%h exp=%h", i, wb_data, exp_tab[i]); end
    end
  endtask

  task automatic test_errors();
    accept(1'b0, 3'b010, 32'h0000_3002, 32'h0);
    vec_cnt++; if ({err_misaligned, err_funct3, mem_req_valid, req_ready} !== 4'b1001) begin err_cnt++; $display("FAIL lw_misal got=%b exp=1001", {err_misaligned, err_funct3, mem_req_valid, req_ready}); end
    tick();
    vec_cnt++; if ({err_misaligned, mem_req_valid} !== 2'b00) begin err_cnt++; $display("FAIL lw_misal_after got=%b exp=00", {err_misaligned, mem_req_valid}); end
    // Illegal funct3 on a misaligned address must report funct3, not alignment.
    accept(1'b0, 3'b011, 32'h0000_3001, 32'h0);
    vec_cnt++; if ({err_funct3, err_misaligned, mem_req_valid} !== 3'b100) begin err_cnt++; $display("FAIL ld_f3 got=%b exp=100", {err_funct3, err_misaligned, mem_req_valid}); end
    accept(1'b1, 3'b100, 32'h0000_3000, 32'h0);
    vec_cnt++; if ({err_funct3, err_misaligned, mem_req_valid} !== 3'b100) begin err_cnt++; $display("FAIL st_f3 got=%b exp=100", {err_funct3, err_misaligned, mem_req_valid}); end
    accept(1'b1, 3'b001, 32'h0000_3001, 32'h0);
    vec_cnt++; if ({err_funct3, err_misaligned, mem_req_valid} !== 3'b010) begin err_cnt++; $display("FAIL sh_misal got=%b exp=010", {err_funct3, err_misaligned, mem_req_valid}); end
    accept(1'b1, 3'b000, 32'h0000_3003, 32'h0000_00EE);
    vec_cnt++; if ({err_funct3, err_misaligned, mem_req_valid, mem_byte_en} !== 7'b001_1000) begin err_cnt++; $display("FAIL sb_3003 got=%b exp=0011000", {err_funct3, err_misaligned, mem_req_valid, mem_byte_en}); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    vec_cnt++; if (store_done !== 1'b1) begin err_cnt++; $display("FAIL sb_3003_done got=%b exp=1", store_done); end
    accept(1'b1, 3'b001, 32'h0000_3002, 32'h1234_5678);
    vec_cnt++; if ({mem_byte_en, mem_wdata} !== {4'b1100, 32'h5678_5678}) begin err_cnt++; $display("FAIL sh_lanes got=%h exp=c56785678", {mem_byte_en, mem_wdata}); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int done_cnt;
    done_cnt = 0;
    accept(1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D);
    req_valid = 1'b1;
    req_addr  = 32'h0000_4444;
    req_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      vec_cnt++; if ({mem_req_valid, req_ready, mem_we, mem_byte_en} !== 7'b101_1111) begin err_cnt++; $display("FAIL bp%0d_ctl got=%b exp=1011111", i, {mem_req_valid, req_ready, mem_we, mem_byte_en}); end
      vec_cnt++; if ({mem_addr, mem_wdata} !== {32'h0000_4000, 32'hCAFE_F00D}) begin err_cnt++; $display("FAIL bp%0d_data got=%h exp=00004000cafef00d", i, {mem_addr, mem_wdata}); end
      tick();
    end
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (store_done === 1'b1) done_cnt++;
      tick();
    end
    vec_cnt++; if (done_cnt !== 1) begin err_cnt++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_timeout();
    accept(1'b0, 3'b010, 32'h0000_5000, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if ({err_timeout, busy} !== 2'b01) begin err_cnt++; $display("FAIL to_wait%0d got=%b exp=01", i, {err_timeout, busy}); end
    end
    tick();
    vec_cnt++; if ({err_timeout, busy, req_ready, wb_valid} !== 4'b1010) begin err_cnt++; $display("FAIL to_pulse got=%b exp=1010", {err_timeout, busy, req_ready, wb_valid}); end
    tick();
    vec_cnt++; if (err_timeout !== 1'b0) begin err_cnt++; $display("FAIL to_width got=%b exp=0", err_timeout); end
    accept(1'b0, 3'b010, 32'h0000_5000, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick(); tick(); tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5_0001;
    tick();
    mem_rvalid = 1'b0;
    vec_cnt++; if ({wb_valid, err_timeout} !== 2'b10) begin err_cnt++; $display("FAIL to_last_rvalid got=%b exp=10", {wb_valid, err_timeout}); end
    vec_cnt++; if (wb_data !== 32'hA5A5_0001) begin err_cnt++; $display("FAIL to_last_data got=%h exp=a5a50001", wb_data); end
    tick();
    vec_cnt++; if ({wb_valid, err_timeout} !== 2'b00) begin err_cnt++; $display("FAIL to_last_after got=%b exp=00", {wb_valid, err_timeout}); end
  endtask

  task automatic test_reset_mid();
    accept(1'b0, 3'b010, 32'h0000_7000, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++; if ({busy, req_ready, mem_addr, wb_data} !== {2'b01, 64'h0}) begin err_cnt++; $display("FAIL rm_async got=%h exp=1", {busy, req_ready, mem_addr, wb_data}); end
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    vec_cnt++; if ({wb_valid, busy, req_ready, wb_data} !== {3'b001, 32'h0}) begin err_cnt++; $display("FAIL rm_ignore got=%h exp=100000000", {wb_valid, busy, req_ready, wb_data}); end
    accept(1'b0, 3'b100, 32'h0000_2003, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_7F01;
    tick();
    mem_rvalid = 1'b0;
    vec_cnt++; if ({wb_valid, wb_data} !== {1'b1, 32'h0000_0080}) begin err_cnt++; $display("FAIL rm_next got=%h exp=100000080", {wb_valid, wb_data}); end
    tick();
  endtask

  task automatic test_back_to_back();
    accept(1'b1, 3'b000, 32'h0000_6000, 32'h0000_0011);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    vec_cnt++; if ({store_done, req_ready} !== 2'b11) begin err_cnt++; $display("FAIL b2b_done got=%b exp=11", {store_done, req_ready}); end
    accept(1'b1, 3'b000, 32'h0000_6001, 32'h0000_0022);
    vec_cnt++; if ({mem_req_valid, mem_byte_en, mem_wdata} !== {5'b1_0010, 32'h2222_2222}) begin err_cnt++; $display("FAIL b2b_second got=%h exp=1222222222", {mem_req_valid, mem_byte_en, mem_wdata}); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    vec_cnt++; if (store_done !== 1'b1) begin err_cnt++; $display("FAIL b2b_second_done got=%b exp=1", store_done); end
    tick();
  endtask

  initial begin
    vec_cnt       = 0;
    err_cnt       = 0;
    req_valid     = 1'b0;
    req_is_store  = 1'b0;
    req_funct3    = 3'b000;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
    test_reset();
    test_sb();
    test_loads();
    test_errors();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_controller.md
# lsu_controller

Load/store sequencing controller between the core's execute stage and the data-memory port. Accepts one load or store request at a time and aligns store data and byte enables per funct3 (F3_BYTE/F3_HALFWORD/F3_WORD). Runs a valid/ready handshake to memory, then sign- or zero-extends load data. Returns load results as a write-back pulse, or reports misalignment, illegal funct3 or memory timeout.

## Interface
- TIMEOUT_CYCLES, 256: max cycles waiting for `mem_rvalid` after a load handshake; range 2..65536.
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept.
- req_is_store  in  1  1 = store (OPCODE_S_TYPE), 0 = load (OPCODE_I_TYPE_LOAD).
- req_funct3  in  3  load_store_funct3_t encoding.
- req_addr  in  32  byte address (ALU_ADD result).
- req_wdata  in  32  store source (rs2).
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}.
- mem_we  out  1  1 = write.
- mem_byte_en  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  32  load data word.
- wb_data  out  32  extended load result (write_back_t.data).
- wb_valid  out  1  one-cycle load-complete pulse (write_back_t.valid).
- store_done  out  1  one-cycle store-complete pulse.
- err_misaligned  out  1  one-cycle pulse.
- err_funct3  out  1  one-cycle pulse.
- err_timeout  out  1  one-cycle pulse.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, REQ, WAIT_RSP, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch addr/funct3/wdata/is_store.
  - Illegal funct3 (loads: 011, 110, 111; stores: anything other than 000, 001, 010): pulse `err_funct3` next cycle, stay IDLE.
  - Misaligned (halfword with addr[0]=1; word with addr[1:0]!=0): pulse `err_misaligned` next cycle, stay IDLE.
  - No memory request is issued for either error. funct3 check has priority over alignment.
  - Otherwise go to REQ.
- REQ: `mem_req_valid`=1. `mem_addr`, `mem_we`, `mem_byte_en` and `mem_wdata` stay stable until `mem_req_ready`.
  - Store on handshake: pulse `store_done`, go to IDLE.
  - Load on handshake: go to WAIT_RSP, clear the timeout counter.
- Store lanes, with off = addr[1:0]:
  - SB: byte_en = 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - SH: byte_en = 4'b0011<<off, wdata = {2{wdata[15:0]}}.
  - SW: byte_en = 4'b1111.
- Loads: `mem_we`=0, `mem_byte_en`=4'b1111.
- WAIT_RSP: counter increments each cycle.
  - On `mem_rvalid`: register the extracted data, go to RESP.
  - If `mem_rvalid` is absent when the counter reaches TIMEOUT_CYCLES-1: pulse `err_timeout`, go to IDLE.
  - `mem_rvalid` in the same cycle as the final count wins; no timeout is raised.
- Load extraction:
  - LB / LBU: byte rdata[8*off+:8], sign- / zero-extended.
  - LH / LHU: half rdata[16*addr[1]+:16], sign- / zero-extended.
  - LW: full word.
- RESP: `wb_valid`=1 for one cycle with `wb_data`, then IDLE.
- `mem_rvalid` outside WAIT_RSP is ignored.
- `wb_data` holds its last value when `wb_valid`=0.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; `req_ready`=1; all other outputs 0, including `mem_*`, `wb_data` and all pulses.
- Reset mid-transaction aborts it with no pulses. An outstanding memory response after reset is ignored.
- All outputs are registered or decoded from state only. No combinational path from `mem_rvalid` or `mem_rdata` to outputs.
- Accept edge → `mem_req_valid` high on the next cycle.
- Store latency: accept at T, `mem_req_ready` at T+1 → `store_done` at T+2.
- Load latency: handshake at T+1, `mem_rvalid` at T+k (k≥2) → `wb_valid` at T+k+1.
- Error pulses occur the cycle after the accept.
- Back-to-back: the cycle after `store_done`, `wb_valid` or any error pulse is IDLE with `req_ready`=1, so a new accept is allowed there. Maximum throughput is one store per 2 cycles.

## Test plan
- SB: addr 0x1003, wdata 0xAABBCCDD → mem_addr 0x1000, byte_en 4'b1000, mem_wdata 0xDDDDDDDD, mem_we 1; `store_done` 1 cycle after the handshake.
- LB / LBU / LH: addr 0x2002, mem_rdata 0x80FF7F01 →
  - LB gives wb_data 0xFFFFFFFF.
  - LBU gives 0x000000FF.
  - LH gives 0xFFFF80FF.
  - Each `wb_valid` is exactly one cycle.
- Errors:
  - LW at 0x3002 → `err_misaligned`, no `mem_req_valid`.
  - Load with funct3 3'b011 → `err_funct3`.
  - SB at 0x3003 → legal, proceeds.
- Memory backpressure: `mem_req_ready` held low 5 cycles → outputs stable, single handshake, `req_ready`=0 throughout.
- Timeout: TIMEOUT_CYCLES=4, no `mem_rvalid` → `err_timeout` 4 cycles after the handshake, back to IDLE. With `mem_rvalid` on the final count → `wb_valid`, no error.
- Reset: assert `rst_n` low in WAIT_RSP, then send `mem_rvalid` after release → no `wb_valid`, all outputs at reset values, next request served normally.
